// File: rtl/compound_op_pkg.sv
// Shared types for the compound-assignment accumulator.
//   op_e            : 4-bit command opcode (13..15 are reserved no-ops)
//   state_e         : control FSM states
//   OP_RESERVED_MIN : first reserved opcode value
package compound_op_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ASHL = 4'd11,
    OP_ASHR = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [3:0] OP_RESERVED_MIN = 4'd13;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   start               : load dividend/divisor and begin WIDTH iterations
//   dividend, divisor   : operands sampled on start
//   done                : high during the cycle of the final iteration;
//                         quotient/remainder are valid after that edge
//   quotient, remainder : results (registered)
module serial_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             fits;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    partial = {remainder, quotient[WIDTH-1]};
    diff    = partial - {1'b0, dsr_q};
    fits    = ~diff[WIDTH];
  end

  // Quotient shares the shift register with the remaining dividend bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dsr_q     <= divisor;
      cnt_q     <= CNT_W'(WIDTH);
      done      <= 1'b0;
    end else if (cnt_q != '0) begin
      remainder <= fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], fits};
      cnt_q     <= cnt_q - CNT_W'(1);
      done      <= (cnt_q == CNT_W'(2));
    end
  end

endmodule

// File: rtl/compound_op_accumulator.sv
// Accumulator executing one compound-assignment op per accepted command.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : command valid; accepted when in_ready is also high
//   in_ready   : block can accept a command (low while a divide runs)
//   in_op      : opcode (op_e), in_operand : right-hand operand
//   acc        : accumulator value
//   out_valid  : one-cycle pulse, acc holds the last command's result
//   div0       : one-cycle pulse with out_valid on divide/modulo by zero
module compound_op_accumulator
  import compound_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic             div0
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_d;
  logic             out_valid_d, div0_d, in_ready_d;
  logic             is_mod_q, is_mod_d;
  logic             accept, is_div, div_zero, shift_big;
  logic [WIDTH-1:0] alu_res;
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign accept    = in_valid && in_ready;
  assign is_div    = (in_op == OP_DIV) || (in_op == OP_MOD);
  assign div_zero  = (in_operand == '0);
  assign shift_big = (in_operand >= WIDTH'(WIDTH));

  // Single-cycle datapath; DIV/MOD here only cover the zero-divisor case.
  always_comb begin
    alu_res = acc;
    if (in_op < OP_RESERVED_MIN) begin
      case (in_op)
        OP_LOAD:         alu_res = in_operand;
        OP_ADD:          alu_res = acc + in_operand;
        OP_SUB:          alu_res = acc - in_operand;
        OP_MUL:          alu_res = acc * in_operand;
        OP_DIV:          alu_res = '1;
        OP_MOD:          alu_res = acc;
        OP_AND:          alu_res = acc & in_operand;
        OP_OR:           alu_res = acc | in_operand;
        OP_XOR:          alu_res = acc ^ in_operand;
        OP_SHL, OP_ASHL: alu_res = shift_big ? '0 : (acc << in_operand);
        OP_SHR:          alu_res = shift_big ? '0 : (acc >> in_operand);
        OP_ASHR:         alu_res = shift_big ? {WIDTH{acc[WIDTH-1]}}
                                             : WIDTH'($signed(acc) >>> in_operand);
        default:         alu_res = acc;
      endcase
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc;
    out_valid_d = 1'b0;
    div0_d      = 1'b0;
    div_start   = 1'b0;
    is_mod_d    = is_mod_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_div && !div_zero) begin
            div_start = 1'b1;
            is_mod_d  = (in_op == OP_MOD);
            state_d   = DIV;
          end else begin
            acc_d       = alu_res;
            out_valid_d = 1'b1;
            div0_d      = is_div;
          end
        end
      end
      // done marks the final iteration, so WB sees settled results.
      DIV: begin
        if (div_done) state_d = WB;
      end
      WB: begin
        acc_d       = is_mod_q ? div_rem : div_quo;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      div0      <= 1'b0;
      in_ready  <= 1'b1;
      is_mod_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc       <= acc_d;
      out_valid <= out_valid_d;
      div0      <= div0_d;
      in_ready  <= in_ready_d;
      is_mod_q  <= is_mod_d;
    end
  end

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (acc),
    .divisor   (in_operand),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule
